cpu7_ifu_imem_slv: RTL

Instruction-memory responder that sits between the IFU fetch datapath and the instruction RAM port. It accepts fetch requests (`inst_req`/`inst_addr`, answered with `inst_addr_ok`), forwards them to a variable-latency RAM, and returns one 32-bit instruction per accepted request on `inst_valid_f`/`inst_rdata_f`. It also honours `inst_cancel` by discarding responses owed to earlier requests, and flags misaligned fetches as ADEF exceptions. At most one request is outstanding; a new request may be accepted in the same cycle the previous response returns.

---
 rtl/cpu7_ifu_imem_slv.sv | 118 +++++++++++
 1 files changed

// File: rtl/cpu7_ifu_imem_slv.sv
// Instruction-memory responder between the IFU fetch path and a variable-latency RAM port.
// Optional misaligned-fetch (ADEF) handling is enabled by defining CPU7_IMEM_ADEF_EN.
module cpu7_ifu_imem_slv #(
   parameter int          GRLEN    = 64,
   parameter logic [31:0] UNC_BASE = 32'h1c00_0000,
   parameter logic [31:0] UNC_MASK = 32'hff00_0000
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             inst_req,
   input  logic [31:0]      inst_addr,
   input  logic             inst_cancel,
   output logic             inst_addr_ok,
   output logic             inst_valid_f,
   output logic [GRLEN-1:0] inst_rdata_f,
   output logic [1:0]       inst_count,
   output logic             inst_ex,
   output logic [5:0]       inst_exccode,
   output logic             inst_uncache,
   output logic             ram_req,
   output logic [31:0]      ram_addr,
   input  logic             ram_gnt,
   input  logic             ram_rvalid,
   input  logic [31:0]      ram_rdata,
   output logic [1:0]       o_dbg_state
);

   // Handshake: a fetch is taken in any cycle where inst_req and inst_addr_ok are both 1;
   // the RAM read is taken where ram_req and ram_gnt are both 1; ram_rvalid is one pulse per grant.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DROP = 2'd2,
      S_EXC  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_uncache;
   logic             w_ret;
   logic             w_free;
   logic             w_adef;
   logic             w_accept;
   logic [GRLEN-1:0] w_rdata;

`ifdef CPU7_IMEM_ADEF_EN
   assign w_adef = (inst_addr[1:0] != 2'b00);
`else
   logic w_unused_addr_lsb;
   assign w_adef            = 1'b0;
   assign w_unused_addr_lsb = ^inst_addr[1:0];
`endif

   assign w_ret    = ((r_state == S_BUSY) || (r_state == S_DROP)) && ram_rvalid;
   assign w_free   = (r_state == S_IDLE) || (r_state == S_EXC) || w_ret;
   assign w_accept = inst_req && w_free && (w_adef || ram_gnt);

   assign ram_req      = inst_req && w_free && !w_adef;
   assign ram_addr     = {inst_addr[31:2], 2'b00};
   assign inst_addr_ok = w_accept;
   assign inst_uncache = r_uncache;
   assign o_dbg_state  = r_state;

   always_comb begin
      w_rdata       = '0;
      w_rdata[31:0] = ram_rdata;
   end

   // Response path is purely combinational from the RAM return and the cancel strobe.
   always_comb begin
      inst_valid_f = 1'b0;
      inst_rdata_f = '0;
      inst_ex      = 1'b0;
      inst_exccode = 6'h00;
      case (r_state)
         S_BUSY: begin
            inst_valid_f = ram_rvalid && !inst_cancel;
            inst_rdata_f = w_rdata;
         end
`ifdef CPU7_IMEM_ADEF_EN
         S_EXC: begin
            inst_valid_f = !inst_cancel;
            inst_ex      = 1'b1;
            inst_exccode = 6'h08;
         end
`endif
         default: ;
      endcase
      inst_count = inst_valid_f ? 2'd1 : 2'd0;
   end

   always_comb begin
      w_next = r_state;
      if (w_accept) begin
         w_next = w_adef ? S_EXC : S_BUSY;
      end else begin
         case (r_state)
            S_BUSY:  w_next = ram_rvalid ? S_IDLE : (inst_cancel ? S_DROP : S_BUSY);
            S_DROP:  w_next = ram_rvalid ? S_IDLE : S_DROP;
            S_EXC:   w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_state   <= S_IDLE;
         r_uncache <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_uncache <= ((inst_addr & UNC_MASK) == UNC_BASE);
         end
      end
   end

endmodule
